// File: rtl/matrix_pkg.sv
// Shared op encodings, FSM state codes and helpers for the matrix coprocessor sequencer.
package matrix_pkg;

    localparam int unsigned MAT_DATA_W = 256;
    localparam int unsigned ELEM_W     = 8;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned ST_W       = 3;
    localparam int unsigned LAT_W      = 4;

    localparam logic [OP_W-1:0] OP_ADD        = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB        = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL_SCALAR = 3'd2;
    localparam logic [OP_W-1:0] OP_TRANSPOSE  = 3'd3;
    localparam logic [OP_W-1:0] OP_NEGATE     = 3'd4;
    localparam logic [OP_W-1:0] OP_MATMUL     = 3'd5;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_RD_A  = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_B  = 3'd2;
    localparam logic [ST_W-1:0] ST_EXEC  = 3'd3;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd5;
    localparam logic [ST_W-1:0] ST_ERR   = 3'd6;

    // Ops that only consume operand A (no second RAM fetch).
    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_TRANSPOSE) || (op == OP_NEGATE);
    endfunction

    // Encodings 6 and 7 are reserved.
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_MATMUL);
    endfunction

endpackage

// File: rtl/seq_lat_counter.sv
// Loadable 4-bit down-counter with a zero flag; times RAM read waits and ALU settle.
module seq_lat_counter
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [LAT_W-1:0] count;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - LAT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Command-driven sequencer: fetch A (and B/scalar), run the matrix ALU, write back.
// Optional performance counters are enabled with `define SEQ_PERF_CNT_EN.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = MAT_DATA_W,
    parameter int unsigned RAM_RD_LAT = 1,
    parameter int unsigned ALU_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [ADDR_W-1:0] cmd_addr_d,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_scalar,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       perf_ops,
    output logic [7:0]        perf_last_cyc
`endif
);

    localparam logic [LAT_W-1:0] RD_LAT_LD  = LAT_W'(RAM_RD_LAT);
    localparam logic [LAT_W-1:0] ALU_LAT_LD = LAT_W'(ALU_LAT);

    logic [ST_W-1:0]   state, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [ADDR_W-1:0] addr_d_q, addr_d_d;

    logic [ADDR_W-1:0] ram_addr_d;
    logic              ram_we_d;
    logic [DATA_W-1:0] ram_wdata_d;
    logic [2:0]        alu_op_d;
    logic [DATA_W-1:0] alu_a_d;
    logic [DATA_W-1:0] alu_b_d;
    logic [7:0]        alu_scalar_d;
    logic              done_d;
    logic              err_d;

    logic              cnt_load;
    logic [LAT_W-1:0]  cnt_val;
    logic              cnt_dec;
    logic              cnt_zero_c;

    seq_lat_counter u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    // Next-state and next-output decode; every register holds unless a state updates it.
    always_comb begin
        state_d      = state;
        op_d         = op_q;
        addr_b_d     = addr_b_q;
        addr_d_d     = addr_d_q;
        ram_addr_d   = ram_addr;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata;
        alu_op_d     = alu_op;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_scalar_d = alu_scalar;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d     = cmd_op;
                    addr_b_d = cmd_addr_b;
                    addr_d_d = cmd_addr_d;
                    if (is_legal(cmd_op)) begin
                        state_d      = ST_RD_A;
                        ram_addr_d   = cmd_addr_a;
                        alu_b_d      = '0;
                        alu_scalar_d = '0;
                        cnt_load     = 1'b1;
                        cnt_val      = RD_LAT_LD;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RD_A: begin
                if (cnt_zero_c) begin
                    alu_a_d = ram_rdata;
                    if (is_unary(op_q)) begin
                        state_d  = ST_EXEC;
                        alu_op_d = op_q;
                        cnt_load = 1'b1;
                        cnt_val  = ALU_LAT_LD;
                    end else begin
                        state_d    = ST_RD_B;
                        ram_addr_d = addr_b_q;
                        cnt_load   = 1'b1;
                        cnt_val    = RD_LAT_LD;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD_B: begin
                if (cnt_zero_c) begin
                    if (op_q == OP_MUL_SCALAR) begin
                        alu_scalar_d = ram_rdata[ELEM_W-1:0];
                    end else begin
                        alu_b_d = ram_rdata;
                    end
                    state_d  = ST_EXEC;
                    alu_op_d = op_q;
                    cnt_load = 1'b1;
                    cnt_val  = ALU_LAT_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_zero_c) begin
                    ram_wdata_d = alu_result;
                    ram_addr_d  = addr_d_q;
                    ram_we_d    = 1'b1;
                    state_d     = ST_WRITE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any sequence with write enable low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            addr_b_q   <= '0;
            addr_d_q   <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_scalar <= '0;
        end else begin
            state      <= state_d;
            op_q       <= op_d;
            addr_b_q   <= addr_b_d;
            addr_d_q   <= addr_d_d;
            cmd_ready  <= (state_d == ST_IDLE);
            busy       <= (state_d != ST_IDLE);
            done       <= done_d;
            err        <= err_d;
            ram_addr   <= ram_addr_d;
            ram_we     <= ram_we_d;
            ram_wdata  <= ram_wdata_d;
            alu_op     <= alu_op_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_scalar <= alu_scalar_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [7:0] run_cyc;

    // Completed-op count and accept-to-done cycle count of the most recent op.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops      <= '0;
            perf_last_cyc <= '0;
            run_cyc       <= '0;
        end else begin
            if (state == ST_IDLE) begin
                run_cyc <= '0;
            end else if (run_cyc != 8'hFF) begin
                run_cyc <= run_cyc + 8'd1;
            end
            if (done_d) begin
                perf_ops      <= perf_ops + 16'd1;
                perf_last_cyc <= (run_cyc == 8'hFF) ? 8'hFF : run_cyc + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a RAM model and a reference matrix ALU.
module tb_matrix_op_sequencer;
    import matrix_pkg::*;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [7:0]   cmd_addr_a;
    logic [7:0]   cmd_addr_b;
    logic [7:0]   cmd_addr_d;
    logic [7:0]   ram_addr;
    logic         ram_we;
    logic [255:0] ram_wdata;
    logic [255:0] ram_rdata;
    logic [2:0]   alu_op;
    logic [255:0] alu_a;
    logic [255:0] alu_b;
    logic [7:0]   alu_scalar;
    logic [255:0] alu_result;
    logic         busy;
    logic         done;
    logic         err;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]  perf_ops;
    logic [7:0]   perf_last_cyc;
`endif

    matrix_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr_a (cmd_addr_a),
        .cmd_addr_b (cmd_addr_b),
        .cmd_addr_d (cmd_addr_d),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_scalar (alu_scalar),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_ops      (perf_ops),
        .perf_last_cyc (perf_last_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency, with a bench-side preload port.
    logic [255:0] mem [0:255];
    logic         tb_we;
    logic [7:0]   tb_addr;
    logic [255:0] tb_data;

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference combinational matrix ALU (5x5 int8 in bytes 0..24).
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'd0: for (int i = 0; i < 32; i++) alu_result[i*8 +: 8] = alu_a[i*8 +: 8] + alu_b[i*8 +: 8];
            3'd1: for (int i = 0; i < 32; i++) alu_result[i*8 +: 8] = alu_a[i*8 +: 8] - alu_b[i*8 +: 8];
            3'd2: for (int i = 0; i < 32; i++) alu_result[i*8 +: 8] = 8'(alu_a[i*8 +: 8] * alu_scalar);
            3'd3: begin
                alu_result = alu_a;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        alu_result[(r*5+c)*8 +: 8] = alu_a[(c*5+r)*8 +: 8];
            end
            3'd4: for (int i = 0; i < 32; i++) alu_result[i*8 +: 8] = 8'(8'd0 - alu_a[i*8 +: 8]);
            3'd5: begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++) begin
                        logic [7:0] acc;
                        acc = 8'd0;
                        for (int k = 0; k < 5; k++)
                            acc = acc + 8'(alu_a[(r*5+k)*8 +: 8] * alu_b[(k*5+c)*8 +: 8]);
                        alu_result[(r*5+c)*8 +: 8] = acc;
                    end
            end
            default: alu_result = '0;
        endcase
    end

    // Event monitor sampled on the falling edge.
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, we_cnt = 0, acc_cnt = 0, addr9_cnt = 0;
    int done_cyc = 0, err_cyc = 0;
    logic [7:0]   we_addr;
    logic [255:0] we_data;
    logic         prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
            we_data <= ram_wdata;
        end
        if (busy && !prev_busy) acc_cnt <= acc_cnt + 1;
        prev_busy <= busy;
        if (busy && (ram_addr == 8'd9)) addr9_cnt <= addr9_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [255:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        step();
        tb_we   = 1'b0;
    endtask

    // Present a command and hold it until accepted; returns the cycle index after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d, output int acc);
        bit ok;
        cmd_op     = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_addr_d = d;
        cmd_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        step();
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    // Wait for the next done or err pulse, bounded.
    task automatic wait_end(input int d0, input int e0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if ((done_cnt > d0) || (err_cnt > e0)) seen = 1'b1;
            else step();
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL end_timeout actual=0 required=1");
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [7:0]   a;
        logic [7:0]   b;
        logic [7:0]   d;
        logic [7:0]   fill_a;
        logic [7:0]   fill_b;
        logic [255:0] exp_data;
        logic [255:0] exp_b;
        logic [7:0]   exp_scalar;
        int           exp_lat;
        bit           exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input int idx);
        vec_t v;
        int d0, e0, w0, a90, acc;
        v = vecs[idx];
        preload(v.a, {32{v.fill_a}});
        if (!is_unary(v.op) && !v.exp_err) preload(v.b, {32{v.fill_b}});
        d0 = done_cnt; e0 = err_cnt; w0 = we_cnt; a90 = addr9_cnt;
        issue(v.op, v.a, v.b, v.d, acc);
        wait_end(d0, e0);
        if (v.exp_err) begin
            chk($sformatf("v%0d err_count", idx), 256'(err_cnt - e0), 256'(1));
            chk($sformatf("v%0d err_cycle", idx), 256'(err_cyc - acc), 256'(0));
            chk($sformatf("v%0d err_no_done", idx), 256'(done_cnt - d0), 256'(0));
        end else begin
            chk($sformatf("v%0d done_count", idx), 256'(done_cnt - d0), 256'(1));
            chk($sformatf("v%0d latency", idx), 256'(done_cyc - acc), 256'(v.exp_lat));
            chk($sformatf("v%0d no_err", idx), 256'(err_cnt - e0), 256'(0));
            chk($sformatf("v%0d wr_addr", idx), 256'(we_addr), 256'(v.d));
            chk($sformatf("v%0d wr_data", idx), we_data, v.exp_data);
            chk($sformatf("v%0d alu_b", idx), alu_b, v.exp_b);
            chk($sformatf("v%0d alu_scalar", idx), 256'(alu_scalar), 256'(v.exp_scalar));
            chk($sformatf("v%0d alu_op", idx), 256'(alu_op), 256'(v.op));
            chk($sformatf("v%0d addr_b_unread", idx), 256'(addr9_cnt - a90), 256'(0));
`ifdef SEQ_PERF_CNT_EN
            chk($sformatf("v%0d perf_last_cyc", idx), 256'(perf_last_cyc), 256'(v.exp_lat));
`endif
        end
        chk($sformatf("v%0d we_count", idx), 256'(we_cnt - w0), 256'(v.exp_err ? 0 : 1));
        step();
        chk($sformatf("v%0d ready_after", idx), 256'(cmd_ready), 256'(1));
        chk($sformatf("v%0d idle_after", idx), 256'({busy, done, err}), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, a0, acc;
        bit idle;

        vecs[0] = '{OP_ADD,        8'd0,  8'd1,  8'd2,  8'h03, 8'h04, {32{8'h07}}, {32{8'h04}}, 8'h00, 8, 1'b0};
        vecs[1] = '{OP_SUB,        8'd3,  8'd5,  8'd6,  8'h10, 8'h03, {32{8'h0D}}, {32{8'h03}}, 8'h00, 8, 1'b0};
        vecs[2] = '{OP_MUL_SCALAR, 8'd0,  8'd1,  8'd2,  8'h02, 8'h05, {32{8'h0A}}, 256'd0,      8'h05, 8, 1'b0};
        vecs[3] = '{OP_TRANSPOSE,  8'd4,  8'd9,  8'd4,  8'h11, 8'h00, {32{8'h11}}, 256'd0,      8'h00, 6, 1'b0};
        vecs[4] = '{OP_NEGATE,     8'd7,  8'd9,  8'd8,  8'h01, 8'h00, {32{8'hFF}}, 256'd0,      8'h00, 6, 1'b0};
        vecs[5] = '{OP_MATMUL,     8'd12, 8'd13, 8'd14, 8'h01, 8'h01, {56'd0, {25{8'h05}}}, {32{8'h01}}, 8'h00, 8, 1'b0};
        vecs[6] = '{OP_ADD,        8'd10, 8'd11, 8'd10, 8'h20, 8'h01, {32{8'h21}}, {32{8'h01}}, 8'h00, 8, 1'b0};
        vecs[7] = '{3'd7,          8'd0,  8'd1,  8'd2,  8'h00, 8'h00, 256'd0,      256'd0,      8'h00, 0, 1'b1};
        vecs[8] = '{3'd6,          8'd0,  8'd1,  8'd2,  8'h00, 8'h00, 256'd0,      256'd0,      8'h00, 0, 1'b1};
        vecs[9] = '{OP_ADD,        8'd0,  8'd0,  8'd3,  8'h40, 8'h40, {32{8'h80}}, {32{8'h40}}, 8'h00, 8, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
        cmd_addr_a = '0; cmd_addr_b = '0; cmd_addr_d = '0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        for (int i = 0; i < 3; i++) step();

        // Reset values.
        chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_ram_we", 256'(ram_we), 256'(0));
        chk("rst_ram_addr", 256'(ram_addr), 256'(0));
        chk("rst_ram_wdata", ram_wdata, 256'(0));
        chk("rst_alu_a", alu_a, 256'(0));
        chk("rst_alu_b", alu_b, 256'(0));
        chk("rst_alu_scalar", 256'(alu_scalar), 256'(0));
        chk("rst_alu_op", 256'(alu_op), 256'(0));
`ifdef SEQ_PERF_CNT_EN
        chk("rst_perf_ops", 256'(perf_ops), 256'(0));
`endif
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_vec(i);

        // cmd_valid held across a busy period: exactly two accepts, two dones.
        preload(8'd0, {32{8'h03}});
        preload(8'd1, {32{8'h04}});
        d0 = done_cnt; w0 = we_cnt; a0 = acc_cnt;
        cmd_op = OP_ADD; cmd_addr_a = 8'd0; cmd_addr_b = 8'd1; cmd_addr_d = 8'd2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 14; i++) step();
        cmd_valid = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin
            if (!busy) idle = 1'b1;
            else step();
        end
        chk("hold_idle_reached", 256'(idle), 256'(1));
        chk("hold_accepts", 256'(acc_cnt - a0), 256'(2));
        chk("hold_dones", 256'(done_cnt - d0), 256'(2));
        chk("hold_writes", 256'(we_cnt - w0), 256'(2));
        chk("hold_ram_addr_kept", 256'(ram_addr), 256'(2));

        // Reset in the middle of EXEC: no write, clean idle, then a normal op.
        preload(8'd0, {32{8'h03}});
        preload(8'd1, {32{8'h04}});
        d0 = done_cnt; w0 = we_cnt;
        issue(OP_ADD, 8'd0, 8'd1, 8'd2, acc);
        for (int i = 0; i < 4; i++) step();
        chk("mid_exec_alu_op", 256'(alu_op), 256'(OP_ADD));
        chk("mid_exec_busy", 256'(busy), 256'(1));
        rst = 1'b1;
        step();
        chk("abort_ram_we", 256'(ram_we), 256'(0));
        chk("abort_flags", 256'({busy, done, err}), 256'(0));
        chk("abort_cmd_ready", 256'(cmd_ready), 256'(1));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("abort_no_write", 256'(we_cnt - w0), 256'(0));
        chk("abort_no_done", 256'(done_cnt - d0), 256'(0));
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
- Command-driven controller for the matrix coprocessor.
- Accepts one operation per valid/ready handshake, then runs the full sequence on the shared single-port 256-bit RAM:
  - fetch operand A;
  - fetch operand B or the scalar, when the op needs it;
  - drive the combinational matrix ALU and wait for it to settle;
  - write the result back and pulse done.
- Replaces hand-stepped count-based sequencing in top levels; sits between the command source (button/switch decoder or host FSM) and the RAM + ALU pair.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 256, RAM word / matrix width (32 bytes; 5x5 int8 uses bytes 0..24)
- RAM_RD_LAT, 1, cycles from ram_addr valid to ram_rdata valid (legal range 1..3)
- ALU_LAT, 2, settle cycles allowed after ALU operands change (legal range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_op  in  3  0 ADD, 1 SUB, 2 MUL_SCALAR, 3 TRANSPOSE, 4 NEGATE, 5 MATMUL, 6-7 illegal
- cmd_addr_a  in  ADDR_W  operand A address
- cmd_addr_b  in  ADDR_W  operand B / scalar address
- cmd_addr_d  in  ADDR_W  destination address
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- alu_op  out  3  ALU operation select (registered)
- alu_a  out  DATA_W  operand A register
- alu_b  out  DATA_W  operand B register
- alu_scalar  out  8  scalar operand
- alu_result  in  DATA_W  ALU result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse when an illegal op is rejected

Behaviour:
- Reset values: cmd_ready=1; busy, done, err, ram_we=0; ram_addr=0; ram_wdata, alu_a, alu_b=0; alu_scalar=0; alu_op=0; state=IDLE.
- Command handling:
  - Accept on clk edge where cmd_valid & cmd_ready; cmd fields latched; cmd_ready drops the next cycle.
  - Illegal op (6, 7): no RAM access; err=1 for one cycle; back to IDLE. Next accept is possible 2 cycles after the rejected accept.
  - Unary ops (TRANSPOSE, NEGATE) skip B fetch; alu_b=0.
  - MUL_SCALAR fetches addr_b; alu_scalar = ram_rdata[7:0]; alu_b unchanged (0).
- States:
  - IDLE: cmd_ready=1.
  - RD_A: ram_addr=addr_a; wait RAM_RD_LAT cycles, then capture alu_a.
  - RD_B: same as RD_A for addr_b; capture into alu_b or alu_scalar.
  - EXEC: alu_op set; count ALU_LAT cycles; then latch alu_result into ram_wdata.
  - WRITE: ram_addr=addr_d, ram_we=1 for exactly one cycle.
  - DONE: done=1 one cycle, then IDLE.
- Latency, accept edge to done-high cycle:
  - binary/scalar ops: 2*RAM_RD_LAT + ALU_LAT + 4 cycles
  - unary ops: RAM_RD_LAT + ALU_LAT + 3 cycles
  - with defaults: 8 (binary/scalar) and 6 (unary)
- Latency counter: single 4-bit down-counter shared by read waits and EXEC.
- addr_d equal to addr_a or addr_b is legal; operands are already captured, so in-place update is correct.
- cmd_valid while busy is ignored (no queueing); the source holds it until cmd_ready.
- rst in any state: aborts immediately; ram_we deasserts the same edge; no partial write occurs after reset.
- ram_we is never high outside WRITE; ram_addr holds its last value in IDLE.

Optional Feature:
- SEQ_PERF_CNT_EN defined:
  - adds outputs perf_ops[15:0], count of completed commands (wraps at 0xFFFF; illegal ops not counted);
  - adds perf_last_cyc[7:0], cycles from accept to done of the last command, saturating at 0xFF;
  - both clear on rst.
- Undefined: ports absent, no counters.

Decomposition:
- Package matrix_pkg:
  - op encodings (OP_ADD..OP_MATMUL);
  - state enum;
  - DATA_W / element width constants;
  - is_unary and is_legal helper functions.
- Sub-module seq_lat_counter: loadable 4-bit down-counter with zero flag, reused for read waits and EXEC.

Test Plan:
- ADD a=0, b=1, d=2; RAM[0] bytes all 3, RAM[1] all 4, model ALU = bytewise add -> one ram_we cycle at addr 2, wdata bytes all 7, done 8 cycles after accept.
- MUL_SCALAR a=0, b=1; RAM[1]=0x05 in low byte, RAM[0] bytes all 2 -> alu_scalar=5, write bytes all 10 at addr 2, alu_b remains 0.
- TRANSPOSE a=4, d=4 -> no read of addr_b, write to addr 4, done 6 cycles after accept.
- cmd_op=7 -> err pulse 1 cycle, ram_we never asserted, cmd_ready back next cycle.
- New cmd_valid held during busy -> not accepted until cmd_ready; exactly one done per accept.
- rst asserted during EXEC -> ram_we stays 0; busy, done, err=0, cmd_ready=1 next cycle; a fresh ADD then completes normally.
